// File: rtl/mult_sched_pkg.sv
// Shared constants and FSM state type for the multiplier request scheduler.
package mult_sched_pkg;

  localparam int MUL_W        = 32;
  localparam int PROD_W       = 64;
  localparam int NOMINAL_LAT  = 36;
  localparam int WATCHDOG_DEF = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_req_scheduler_if.sv
// Request/response handshake bundle between client blocks and the scheduler.
interface mult_req_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*MUL_W-1:0] req_a;
  logic [NUM_REQ*MUL_W-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [PROD_W-1:0]        rsp_data;
  logic                     rsp_err;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/mult_req_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W:0]   pos;
  logic [ID_W-1:0] cand;

  // Scan from the pointer upwards; the first hit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = '0;
    cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
      cand = pos[ID_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mult_req_scheduler.sv
// Shares one sequential 32x32 signed multiplier among NUM_REQ requesters.
module mult_req_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int WATCHDOG = WATCHDOG_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mult_req_scheduler_if.slave bus,
  output logic [MUL_W-1:0]    mul_in1,
  output logic [MUL_W-1:0]    mul_in2,
  output logic                mul_en,
  output logic                mul_rst,
  input  logic [PROD_W-1:0]   mul_result,
  input  logic                mul_done
);

  localparam int WD_W = (WATCHDOG > 2) ? $clog2(WATCHDOG) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [WD_W-1:0]    wd;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [MUL_W-1:0]   a_sel, b_sel;
  logic               en_nxt, rst_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Select the granted requester's operands (grant is one-hot).
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        a_sel = bus.req_a[i*MUL_W +: MUL_W];
        b_sel = bus.req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  // Next state, handshake outputs and next multiplier pin levels.
  // mul_en/mul_rst are registered from the next state so that reset can force
  // mul_rst=1 while the same pins read en=1,rst=1 throughout CLEAR.
  always_comb begin
    state_nxt     = state;
    en_nxt        = 1'b0;
    rst_nxt       = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          bus.req_ready = gnt_oh;
          state_nxt     = ST_CLEAR;
          en_nxt        = 1'b1;
          rst_nxt       = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_WAIT;
        en_nxt    = 1'b1;
      end
      ST_WAIT: begin
        if (mul_done || wd == WD_LAST) state_nxt = ST_RESP;
        else                           en_nxt    = 1'b1;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and multiplier control pins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      mul_en  <= 1'b0;
      mul_rst <= 1'b1;
    end else begin
      state   <= state_nxt;
      mul_en  <= en_nxt;
      mul_rst <= rst_nxt;
    end
  end

  // Operand capture, round-robin pointer, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr          <= '0;
      wd           <= '0;
      mul_in1      <= '0;
      mul_in2      <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            mul_in1    <= a_sel;
            mul_in2    <= b_sel;
            bus.rsp_id <= gnt_idx;
            ptr        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_CLEAR: wd <= '0;
        ST_WAIT: begin
          wd <= wd + 1'b1;
          if (mul_done) begin
            bus.rsp_data <= mul_result;
            bus.rsp_err  <= 1'b0;
          end else if (wd == WD_LAST) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
